mem_port_arbiter: RTL and testbench

Responder for the LC-3b pipeline's two memory ports: it accepts instruction-fetch requests and data load/store requests, and serialises them onto one shared physical-memory port. It answers each port with a one-cycle response pulse.
- Sits between the datapath/control (`instr_*`, `mem_*`) and the physical memory or cache (`pmem_*`).
- Data accesses have priority over fetches, with a bounded-starvation guarantee for the fetch port.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates LC-3b fetch and data ports onto one physical memory port.
// Data has priority; a saturating streak counter bounds fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             instr_read,
  input  logic [WIDTH-1:0] instr_address,
  output logic [WIDTH-1:0] instr_rdata,
  output logic             instr_resp,

  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_resp,

  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_byte_enable,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  localparam int unsigned STREAK_W   = 2;
  localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state;
  logic [STREAK_W-1:0]  streak;
  logic                 data_req_c;
  logic                 streak_ok_c;
  logic                 data_win_c;

  // Data wins unless it has already taken MAX_D_STREAK grants past a waiting fetch.
  assign data_req_c  = mem_read | mem_write;
  assign streak_ok_c = (32'(streak) < MAX_D_STREAK);
  assign data_win_c  = data_req_c & (streak_ok_c | ~instr_read);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      streak           <= '0;
      instr_rdata      <= '0;
      instr_resp       <= 1'b0;
      mem_rdata        <= '0;
      mem_resp         <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= 2'b00;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
    end else begin
      instr_resp <= 1'b0;
      mem_resp   <= 1'b0;
      case (state)
        IDLE: begin
          if (data_win_c) begin
            pmem_address     <= mem_address;
            pmem_wdata       <= mem_wdata;
            pmem_byte_enable <= mem_byte_enable;
            pmem_write       <= mem_write;
            pmem_read        <= mem_read & ~mem_write;
            if (instr_read) begin
              streak <= (streak == STREAK_SAT) ? streak : streak + STREAK_W'(1);
            end else begin
              streak <= '0;
            end
            state <= D_BUSY;
          end else if (instr_read) begin
            pmem_address     <= instr_address;
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
            pmem_byte_enable <= 2'b11;
            streak           <= '0;
            state            <= I_BUSY;
          end
        end

        I_BUSY: begin
          if (pmem_resp) begin
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            instr_rdata <= pmem_rdata;
            instr_resp  <= 1'b1;
            state       <= RESP;
          end
        end

        D_BUSY: begin
          // The latched read strobe tells a load from a store.
          if (pmem_resp) begin
            if (pmem_read) begin
              mem_rdata <= pmem_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory responder.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_read;
  logic [15:0] instr_address;
  logic [15:0] instr_rdata;
  logic        instr_resp;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  logic        model_resp;
  logic        spur_resp;
  assign pmem_resp = model_resp | spur_resp;

  mem_port_arbiter #(.WIDTH(16), .MAX_D_STREAK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_rdata(instr_rdata), .instr_resp(instr_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit          is_data;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat = 1;
  int          i_pulses = 0;
  int          d_pulses = 0;
  int          stable_bad = 0;
  int          strobe_cycles = 0;
  logic        cap_read, cap_write;
  logic [1:0]  cap_be;
  logic [15:0] cap_addr, cap_wdata;
  logic [15:0] exp_mem_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Memory responder: raises pmem_resp in the lat-th cycle the strobe is held.
  initial begin
    int cnt;
    cnt = 0;
    model_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_read || pmem_write) begin
        if (cnt == 0) begin
          cap_read = pmem_read; cap_write = pmem_write; cap_be = pmem_byte_enable;
          cap_addr = pmem_address; cap_wdata = pmem_wdata;
          strobe_cycles = 0;
        end else if (pmem_read !== cap_read || pmem_write !== cap_write ||
                     pmem_byte_enable !== cap_be || pmem_address !== cap_addr ||
                     pmem_wdata !== cap_wdata) begin
          stable_bad++;
        end
        cnt++;
        strobe_cycles++;
        if (cnt == lat) begin
          model_resp = 1'b1;
          pmem_rdata = rd_fn(pmem_address);
        end else begin
          model_resp = 1'b0;
        end
      end else begin
        cnt = 0;
        model_resp = 1'b0;
      end
    end
  end

  // Response pulse counters, sampled mid-cycle.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (instr_resp) i_pulses++;
      if (mem_resp) d_pulses++;
    end
  end

  task automatic wait_resp(output bit got_i, output bit got_d, output int cyc);
    got_i = 0; got_d = 0; cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (instr_resp || mem_resp) begin
        got_i = instr_resp; got_d = mem_resp;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_read = 0; instr_address = '0; mem_read = 0; mem_write = 0;
    mem_byte_enable = '0; mem_address = '0; mem_wdata = '0; spur_resp = 0;
    exp_mem_rdata = '0;
    #3;
    total_cnt++; if ({pmem_read, pmem_write, instr_resp, mem_resp} !== 4'b0) $display("FAIL reset_strobes got=%b exp=0000", {pmem_read, pmem_write, instr_resp, mem_resp}); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (instr_rdata !== 16'h0 || mem_rdata !== 16'h0) $display("FAIL reset_rdata got=%h/%h exp=0000/0000", instr_rdata, mem_rdata); else pass_cnt++;
    total_cnt++; if (pmem_address !== 16'h0 || pmem_wdata !== 16'h0 || pmem_byte_enable !== 2'b00) $display("FAIL reset_pmem got=%h/%h/%b exp=0/0/00", pmem_address, pmem_wdata, pmem_byte_enable); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    exp_t e; bit gi, gd; int cyc, d0, i0, sb0;
    d0 = d_pulses; i0 = i_pulses; sb0 = stable_bad; lat = 1;
    instr_address = 16'h3000; instr_read = 1;
    sb.push_back('{1'b0, 16'h1234});
    wait_resp(gi, gd, cyc);
    instr_read = 0;
    e = sb.pop_front();
    total_cnt++; if (gi !== !e.is_data || gd !== e.is_data) $display("FAIL fetch_kind got=i%0d/d%0d exp_data=%0d", gi, gd, e.is_data); else pass_cnt++;
    total_cnt++; if (instr_rdata !== e.rdata) $display("FAIL fetch_rdata got=%h exp=%h", instr_rdata, e.rdata); else pass_cnt++;
    total_cnt++; if (cyc !== 2) $display("FAIL fetch_latency got=%0d exp=2", cyc); else pass_cnt++;
    total_cnt++; if (strobe_cycles !== 1 || cap_read !== 1'b1 || cap_write !== 1'b0) $display("FAIL fetch_strobe got=%0d r%b w%b exp=1 r1 w0", strobe_cycles, cap_read, cap_write); else pass_cnt++;
    total_cnt++; if (cap_addr !== 16'h3000 || cap_be !== 2'b11) $display("FAIL fetch_addr got=%h/%b exp=3000/11", cap_addr, cap_be); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (i_pulses - i0 !== 1 || d_pulses !== d0 || instr_resp !== 1'b0) $display("FAIL fetch_pulses got=i%0d d%0d exp=i1 d0", i_pulses - i0, d_pulses - d0); else pass_cnt++;
    total_cnt++; if (stable_bad !== sb0) $display("FAIL fetch_stable got=%0d exp=0", stable_bad - sb0); else pass_cnt++;
  endtask

  task automatic test_store();
    exp_t e; bit gi, gd; int cyc, d0, sb0;
    d0 = d_pulses; sb0 = stable_bad; lat = 3;
    mem_address = 16'h0041; mem_wdata = 16'hAB00; mem_byte_enable = 2'b10; mem_write = 1;
    sb.push_back('{1'b1, exp_mem_rdata});
    wait_resp(gi, gd, cyc);
    mem_write = 0;
    e = sb.pop_front();
    total_cnt++; if (gd !== e.is_data || gi !== !e.is_data) $display("FAIL store_kind got=i%0d/d%0d exp_data=%0d", gi, gd, e.is_data); else pass_cnt++;
    total_cnt++; if (mem_rdata !== e.rdata) $display("FAIL store_rdata got=%h exp=%h", mem_rdata, e.rdata); else pass_cnt++;
    total_cnt++; if (cyc !== 4 || strobe_cycles !== 3) $display("FAIL store_latency got=%0d/%0d exp=4/3", cyc, strobe_cycles); else pass_cnt++;
    total_cnt++; if (cap_write !== 1'b1 || cap_read !== 1'b0) $display("FAIL store_strobe got=r%b w%b exp=r0 w1", cap_read, cap_write); else pass_cnt++;
    total_cnt++; if (cap_addr !== 16'h0041 || cap_wdata !== 16'hAB00 || cap_be !== 2'b10) $display("FAIL store_payload got=%h/%h/%b exp=0041/ab00/10", cap_addr, cap_wdata, cap_be); else pass_cnt++;
    total_cnt++; if (stable_bad !== sb0) $display("FAIL store_stable got=%0d exp=0", stable_bad - sb0); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (d_pulses - d0 !== 1 || mem_resp !== 1'b0) $display("FAIL store_pulses got=%0d exp=1", d_pulses - d0); else pass_cnt++;
  endtask

  task automatic test_rw_both();
    exp_t e; bit gi, gd; int cyc;
    lat = 2;
    mem_address = 16'h0200; mem_wdata = 16'h1111; mem_byte_enable = 2'b01;
    mem_read = 1; mem_write = 1;
    sb.push_back('{1'b1, exp_mem_rdata});
    wait_resp(gi, gd, cyc);
    mem_read = 0; mem_write = 0;
    e = sb.pop_front();
    total_cnt++; if (gd !== e.is_data || gi !== !e.is_data) $display("FAIL rw_kind got=i%0d/d%0d exp_data=%0d", gi, gd, e.is_data); else pass_cnt++;
    total_cnt++; if (cap_write !== 1'b1 || cap_read !== 1'b0) $display("FAIL rw_strobe got=r%b w%b exp=r0 w1", cap_read, cap_write); else pass_cnt++;
    total_cnt++; if (mem_rdata !== e.rdata) $display("FAIL rw_rdata got=%h exp=%h", mem_rdata, e.rdata); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    exp_t e; bit gi, gd; int cyc;
    bit kinds [6];
    logic [15:0] obs;
    kinds = '{1, 1, 0, 1, 1, 0};
    lat = 1;
    instr_address = 16'h3000; mem_address = 16'h0100;
    instr_read = 1; mem_read = 1;
    for (int n = 0; n < 6; n++) begin
      sb.push_back('{kinds[n], kinds[n] ? (16'h0100 ^ 16'h5A5A) : 16'h1234});
    end
    for (int n = 0; n < 6; n++) begin
      wait_resp(gi, gd, cyc);
      if (n == 5) begin instr_read = 0; mem_read = 0; end
      e = sb.pop_front();
      if (e.is_data && gd) exp_mem_rdata = e.rdata;
      obs = e.is_data ? mem_rdata : instr_rdata;
      total_cnt++; if (gd !== e.is_data || gi !== !e.is_data) $display("FAIL sim_order[%0d] got=i%0d/d%0d exp_data=%0d", n, gi, gd, e.is_data); else pass_cnt++;
      total_cnt++; if (obs !== e.rdata) $display("FAIL sim_rdata[%0d] got=%h exp=%h", n, obs, e.rdata); else pass_cnt++;
      total_cnt++; if (cyc !== ((n == 0) ? 2 : 3)) $display("FAIL sim_spacing[%0d] got=%0d exp=%0d", n, cyc, (n == 0) ? 2 : 3); else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e; bit gi, gd; int cyc, d0;
    lat = 5;
    mem_address = 16'h0300; mem_read = 1;
    repeat (3) @(negedge clk);
    total_cnt++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0300) $display("FAIL rmid_busy got=%b/%h exp=1/0300", pmem_read, pmem_address); else pass_cnt++;
    d0 = d_pulses;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({pmem_read, pmem_write, mem_resp, instr_resp} !== 4'b0) $display("FAIL rmid_strobes got=%b exp=0000", {pmem_read, pmem_write, mem_resp, instr_resp}); else pass_cnt++;
    total_cnt++; if (pmem_address !== 16'h0 || mem_rdata !== 16'h0 || instr_rdata !== 16'h0) $display("FAIL rmid_regs got=%h/%h/%h exp=0/0/0", pmem_address, mem_rdata, instr_rdata); else pass_cnt++;
    exp_mem_rdata = '0;
    mem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total_cnt++; if (d_pulses !== d0) $display("FAIL rmid_noresp got=%0d exp=0", d_pulses - d0); else pass_cnt++;
    lat = 1;
    instr_address = 16'h3000; instr_read = 1;
    sb.push_back('{1'b0, 16'h1234});
    wait_resp(gi, gd, cyc);
    instr_read = 0;
    e = sb.pop_front();
    total_cnt++; if (gi !== !e.is_data || instr_rdata !== e.rdata || cyc !== 2) $display("FAIL rmid_refetch got=i%0d %h cyc%0d exp=i1 %h cyc2", gi, instr_rdata, cyc, e.rdata); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_spurious();
    exp_t e; bit gi, gd; int cyc, d0, i0;
    d0 = d_pulses; i0 = i_pulses;
    spur_resp = 1;
    @(negedge clk);
    spur_resp = 0;
    repeat (2) @(negedge clk);
    total_cnt++; if (i_pulses !== i0 || d_pulses !== d0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) $display("FAIL spur_quiet got=i%0d d%0d r%b w%b exp=0 0 0 0", i_pulses - i0, d_pulses - d0, pmem_read, pmem_write); else pass_cnt++;
    lat = 2;
    mem_address = 16'h0042; mem_read = 1;
    sb.push_back('{1'b1, 16'h0042 ^ 16'h5A5A});
    wait_resp(gi, gd, cyc);
    mem_read = 0;
    e = sb.pop_front();
    total_cnt++; if (gd !== e.is_data || mem_rdata !== e.rdata) $display("FAIL spur_load got=d%0d %h exp=d1 %h", gd, mem_rdata, e.rdata); else pass_cnt++;
    total_cnt++; if (cyc !== 3) $display("FAIL spur_latency got=%0d exp=3", cyc); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_rw_both();
    test_simultaneous();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
